// File: rtl/bs_adder_driver.sv
// Drives an external bit-serial adder: loads an operand pair, streams it LSB first,
// collects the serial sum bits after a fixed latency and presents the parallel result.
module bs_adder_driver #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned ZLAT  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             x,
    output logic             y,
    output logic             clr,
    input  logic             z,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum
);

    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {IDLE, CLR, SHIFT, DRAIN, HOLD} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic [CW-1:0]    bit_q;
    logic [CW-1:0]    cap_q;
    logic             x_q;
    logic             y_q;
    logic             clr_q;
    logic             out_valid_q;
    logic             cap_v;

    // Capture strobe: the SHIFT flag delayed by the adder's z latency.
    generate
        if (ZLAT == 0) begin : g_nolat
            assign cap_v = (state_q == SHIFT);
        end else begin : g_lat
            logic [ZLAT-1:0] pipe_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    pipe_q <= '0;
                end else begin
                    pipe_q[0] <= (state_q == SHIFT);
                    for (int i = 1; i < int'(ZLAT); i++) begin
                        pipe_q[i] <= pipe_q[i-1];
                    end
                end
            end
            assign cap_v = pipe_q[ZLAT-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            bit_q       <= '0;
            cap_q       <= '0;
            x_q         <= 1'b0;
            y_q         <= 1'b0;
            clr_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            x_q   <= 1'b0;
            y_q   <= 1'b0;
            clr_q <= 1'b0;

            // Serial sum bits enter at the MSB so bit k settles at sum[k].
            if (cap_v) begin
                sum_q <= {z, sum_q[WIDTH-1:1]};
                cap_q <= cap_q + 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        clr_q   <= 1'b1;
                        state_q <= CLR;
                    end
                end
                CLR: begin
                    bit_q   <= '0;
                    cap_q   <= '0;
                    x_q     <= a_q[0];
                    y_q     <= b_q[0];
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    state_q <= SHIFT;
                end
                SHIFT: begin
                    bit_q <= bit_q + 1'b1;
                    if (bit_q != CW'(WIDTH - 1)) begin
                        x_q <= a_q[0];
                        y_q <= b_q[0];
                        a_q <= a_q >> 1;
                        b_q <= b_q >> 1;
                    end else begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: ;
                HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // Last capture completes the word, from SHIFT (ZLAT=0) or DRAIN.
            if (cap_v && (cap_q == CW'(WIDTH - 1))) begin
                out_valid_q <= 1'b1;
                state_q     <= HOLD;
            end
        end
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign x         = x_q;
    assign y         = y_q;
    assign clr       = clr_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;

endmodule

// File: tb/tb_bs_adder_driver.sv
// Directed and random checks of bs_adder_driver against a registered serial adder model.
module tb_bs_adder_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       x;
    logic       y;
    logic       clr;
    logic       z;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] sum;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int          cyc = 0;
    int          last_acc = 0;
    logic [7:0]  exp_q[$];
    logic        c_m;
    logic        z_m;

    bs_adder_driver #(.WIDTH(8), .ZLAT(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .x(x), .y(y), .clr(clr), .z(z),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Serial adder: one-cycle registered sum bit, carry cleared by clr.
    always @(posedge clk) begin
        if (rst || clr) begin
            c_m <= 1'b0;
            z_m <= 1'b0;
        end else begin
            z_m <= x ^ y ^ c_m;
            c_m <= (x & y) | (c_m & (x ^ y));
        end
    end
    assign z = z_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full word: offer, check serial stream, latency, optional stall in HOLD, result.
    task automatic do_word(input logic [7:0] av, input logic [7:0] bv, input int hold,
                           input int exp_period);
        int         t;
        int         lat;
        int         acc;
        logic [7:0] exp;
        logic [7:0] s0;
        @(negedge clk);
        a = av;
        b = bv;
        in_valid = 1'b1;
        out_ready = (hold == 0);
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("in_ready_offer", in_ready, 1);
        exp_q.push_back(av + bv);
        @(posedge clk);
        #1;
        acc = cyc;
        if (exp_period > 0) chk("accept_period", acc - last_acc, exp_period);
        last_acc = acc;
        in_valid = 1'b0;
        chk("clr_pulse", clr, 1);
        chk("in_ready_busy", in_ready, 0);
        chk("x_in_clr", x, 0);
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            chk("x_bit", x, av[k]);
            chk("y_bit", y, bv[k]);
            chk("clr_low", clr, 0);
        end
        lat = 9;
        @(posedge clk);
        #1;
        chk("x_after_shift", x, 0);
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("out_valid_latency", lat, 10);
        if (hold > 0) begin
            a = 8'hEE;
            b = 8'h11;
            in_valid = 1'b1;
            s0 = sum;
            repeat (hold) begin
                @(posedge clk);
                #1;
                chk("hold_sum_stable", sum, s0);
                chk("hold_in_ready", in_ready, 0);
                chk("hold_out_valid", out_valid, 1);
            end
            @(negedge clk);
            out_ready = 1'b1;
        end
        exp = exp_q.pop_front();
        chk("sum", sum, exp);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("out_valid_drop", out_valid, 0);
        chk("idle_in_ready", in_ready, 1);
        chk("sum_retained", sum, exp);
    endtask

    initial begin
        logic ov_seen;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_xy", {x, y}, 0);
        chk("rst_clr", clr, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("in_ready_after_rst", in_ready, 1);

        do_word(8'h05, 8'h03, 0, 0);
        do_word(8'hA5, 8'h00, 0, 12);
        do_word(8'hFF, 8'h01, 0, 12);
        do_word(8'h01, 8'h01, 0, 12);
        do_word(8'h3C, 8'h4B, 5, 0);

        // Abort on the 4th SHIFT cycle.
        @(negedge clk);
        a = 8'h33;
        b = 8'h44;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_xy", {x, y}, 0);
        chk("abort_sum", sum, 0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready_rst", in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_in_ready", in_ready, 1);
        ov_seen = 1'b0;
        repeat (15) begin
            @(posedge clk);
            #1;
            ov_seen = ov_seen | out_valid;
        end
        chk("abort_no_out_valid", ov_seen, 0);
        do_word(8'h10, 8'h20, 0, 0);

        for (int i = 0; i < 16; i++) begin
            do_word(8'($urandom), 8'($urandom), 0, (i == 0) ? 0 : 12);
        end
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
